tap_masked_and_dr: RTL



---
 rtl/tap_masked_and_dr.sv | 81 ++++++++
 1 files changed

// File: rtl/tap_masked_and_dr.sv
// tap_masked_and_dr: registered per-channel masked AND array whose enable mask
// is programmed through a JTAG-style capture/shift/update data register.
// Optional: define TAP_MASKED_AND_STICKY_EN to enable the sticky_low flag
// (set whenever c_all loads 0, cleared by sel&update_dr, set wins).
module tap_masked_and_dr #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MASK_INIT = 1
) (
    input  logic             tck,
    input  logic             trst_n,
    input  logic             sel,
    input  logic             capture_dr,
    input  logic             shift_dr,
    input  logic             update_dr,
    input  logic             tdi,
    output logic             tdo,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             c_all,
    output logic [WIDTH-1:0] mask_out,
    output logic             sticky_low
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] ab_c;
    logic [WIDTH-1:0] mask_rst_c;
    logic             c_all_nxt_c;

    assign ab_c        = a & b;
    assign mask_rst_c  = (MASK_INIT != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    // Disabled channels are forced to 1 so they never fail the reduction.
    assign c_all_nxt_c = &(ab_c | ~mask);

    // Masked datapath: uses the mask held before this edge.
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            c     <= '0;
            c_all <= 1'b0;
        end else begin
            c     <= ab_c & mask;
            c_all <= c_all_nxt_c;
        end
    end

    // Scan register and mask: strobe priority capture > shift > update.
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            sr   <= '0;
            mask <= mask_rst_c;
        end else if (sel) begin
            if (capture_dr) begin
                sr <= ab_c;
            end else if (shift_dr) begin
                sr <= {tdi, sr[WIDTH-1:1]};
            end else if (update_dr) begin
                mask <= sr;
            end
        end
    end

`ifdef TAP_MASKED_AND_STICKY_EN
    // Sticky flag: latches any cycle where c_all loads 0; set beats clear.
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            sticky_low <= 1'b0;
        end else if (!c_all_nxt_c) begin
            sticky_low <= 1'b1;
        end else if (sel && update_dr) begin
            sticky_low <= 1'b0;
        end
    end
`else
    assign sticky_low = 1'b0;
`endif

    assign tdo      = sr[0];
    assign mask_out = mask;

endmodule
